fact_accel_ctrl: RTL and testbench

- Memory-mapped iterative factorial accelerator for the MIPS system bus.
- Sits beside data memory and GPIO in the address decoder. Software writes N, pulses Go, polls Status, then reads Result.
- A control FSM sequences a one-multiply-per-cycle datapath.
- Provides a sequenced hardware resource that software can use to exercise data-memory-mapped I/O from test programs.

---
 rtl/fact_pkg.sv | 26 ++
 rtl/fact_accel_ctrl_dp.sv | 56 +++++
 rtl/fact_accel_ctrl.sv | 134 +++++++++++++
 tb/tb_fact_accel_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/fact_pkg.sv
// Shared definitions for the memory-mapped factorial accelerator:
// FSM encoding, register offsets and Status bit positions.
package fact_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] MULT = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = IDLE,
        S_LOAD = LOAD,
        S_MULT = MULT,
        S_DONE = DONE
    } fact_state_e;

    localparam logic [1:0] ADDR_N      = 2'd0;
    localparam logic [1:0] ADDR_GO     = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;
    localparam logic [1:0] ADDR_RESULT = 2'd3;

    localparam int STAT_DONE = 0;
    localparam int STAT_ERR  = 1;
    localparam int STAT_BUSY = 2;

endpackage

// File: rtl/fact_accel_ctrl_dp.sv
// Factorial datapath: running product, down-counter and result register,
// stepped one multiply per cycle by the control FSM.
module fact_dp #(
    parameter int N_WIDTH    = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_en,
    input  logic                  mult_en,
    input  logic                  res_en,
    input  logic                  res_clr,
    input  logic [N_WIDTH-1:0]    n,
    output logic                  cnt_gt1,
    output logic [DATA_WIDTH-1:0] result
);

    logic [DATA_WIDTH-1:0] prod_q, prod_d;
    logic [N_WIDTH-1:0]    cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;

    always_comb begin
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        if (load_en) begin
            prod_d = DATA_WIDTH'(1);
            cnt_d  = n;
        end else if (mult_en) begin
            // Product is kept to DATA_WIDTH bits; overflow cannot occur for N <= MAX_N.
            prod_d = prod_q * {{(DATA_WIDTH-N_WIDTH){1'b0}}, cnt_q};
            cnt_d  = cnt_q - N_WIDTH'(1);
        end
        if (res_clr) begin
            result_d = '0;
        end else if (res_en) begin
            result_d = prod_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prod_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign cnt_gt1 = (cnt_q > N_WIDTH'(1));
    assign result  = result_q;

endmodule

// File: rtl/fact_accel_ctrl.sv
// Bus-facing factorial accelerator: N/Go/Status/Result registers, control FSM
// and read mux; the arithmetic lives in fact_dp.
module fact_accel_ctrl
    import fact_pkg::*;
#(
    parameter int N_WIDTH    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_N      = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [1:0]            addr,
    input  logic [DATA_WIDTH-1:0] wd,
    output logic [DATA_WIDTH-1:0] rd,
    output logic                  busy,
    output logic                  done
);

    fact_state_e          state_q, state_d;
    logic [N_WIDTH-1:0]   n_q, n_d;
    logic                 go_q, go_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic                 load_en, mult_en, res_en, res_clr, cnt_gt1;
    logic                 busy_w;
    logic [DATA_WIDTH-1:0] result;
    logic                 unused_wd;

    assign busy_w    = (state_q == S_LOAD) || (state_q == S_MULT);
    assign unused_wd = ^wd[DATA_WIDTH-1:N_WIDTH];

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        go_d    = go_q;
        done_d  = done_q;
        err_d   = err_q;
        load_en = 1'b0;
        mult_en = 1'b0;
        res_en  = 1'b0;
        res_clr = 1'b0;

        // Bus writes are only accepted from IDLE or DONE.
        if (we && !busy_w) begin
            if (addr == ADDR_N) begin
                n_d = wd[N_WIDTH-1:0];
            end else if (addr == ADDR_GO) begin
                if (wd[0]) begin
                    go_d    = 1'b1;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    state_d = S_LOAD;
                end else begin
                    go_d = 1'b0;
                end
            end
        end

        case (state_q)
            S_LOAD: begin
                if (n_q > N_WIDTH'(MAX_N)) begin
                    res_clr = 1'b1;
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    load_en = 1'b1;
                    state_d = S_MULT;
                end
            end
            S_MULT: begin
                if (cnt_gt1) begin
                    mult_en = 1'b1;
                end else begin
                    res_en  = 1'b1;
                    done_d  = 1'b1;
                    go_d    = 1'b0;
                    state_d = S_DONE;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            go_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            go_q    <= go_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    fact_dp #(
        .N_WIDTH   (N_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_dp (
        .clk    (clk),
        .rst    (rst),
        .load_en(load_en),
        .mult_en(mult_en),
        .res_en (res_en),
        .res_clr(res_clr),
        .n      (n_q),
        .cnt_gt1(cnt_gt1),
        .result (result)
    );

    always_comb begin
        rd = '0;
        case (addr)
            ADDR_N:      rd = {{(DATA_WIDTH-N_WIDTH){1'b0}}, n_q};
            ADDR_GO:     rd = {{(DATA_WIDTH-1){1'b0}}, go_q};
            ADDR_STATUS: begin
                rd[STAT_BUSY] = busy_w;
                rd[STAT_ERR]  = err_q;
                rd[STAT_DONE] = done_q;
            end
            default:     rd = result;
        endcase
    end

    assign busy = busy_w;
    assign done = done_q;

endmodule

// File: tb/tb_fact_accel_ctrl.sv
// Directed bench for fact_accel_ctrl: bus writes of N/Go, cycle-exact done
// latency, Result/Status values, ignored writes while busy and async reset.
module tb_fact_accel_ctrl;
    import fact_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        busy;
    logic        done;

    int n_asserts = 0;
    int n_fail    = 0;

    always #5 clk = ~clk;

    fact_accel_ctrl #(
        .N_WIDTH   (4),
        .DATA_WIDTH(32),
        .MAX_N     (12)
    ) dut (
        .clk (clk),
        .rst (rst),
        .we  (we),
        .addr(addr),
        .wd  (wd),
        .rd  (rd),
        .busy(busy),
        .done(done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_asserts++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Returns 1ns after the posedge that samples the write (edge E).
    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        we   = 1'b1;
        addr = a;
        wd   = d;
        @(posedge clk);
        #1;
        we = 1'b0;
        wd = 32'd0;
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = rd;
    endtask

    task automatic run_fact(input int n, input logic [31:0] exp_res, input int lat, input bit exp_err);
        logic [31:0] v;
        bus_wr(ADDR_N, 32'(n));
        bus_wr(ADDR_GO, 32'd1);
        chk($sformatf("busy_after_go_n%0d", n), 32'(busy), 32'd1);
        chk($sformatf("done_clr_on_go_n%0d", n), 32'(done), 32'd0);
        for (int i = 1; i < lat; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("done_early_n%0d_e%0d", n, i), 32'(done), 32'd0);
            chk($sformatf("busy_run_n%0d_e%0d", n, i), 32'(busy), 32'd1);
        end
        @(posedge clk);
        #1;
        chk($sformatf("done_n%0d", n), 32'(done), 32'd1);
        chk($sformatf("busy_end_n%0d", n), 32'(busy), 32'd0);
        bus_rd(ADDR_RESULT, v);
        chk($sformatf("result_n%0d", n), v, exp_res);
        bus_rd(ADDR_STATUS, v);
        chk($sformatf("status_n%0d", n), v, exp_err ? 32'h3 : 32'h1);
    endtask

    initial begin
        logic [31:0] v;
        rst  = 1'b0;
        we   = 1'b0;
        addr = 2'd0;
        wd   = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Reset state
        for (int a = 0; a < 4; a++) begin
            bus_rd(2'(a), v);
            chk($sformatf("reset_rd_addr%0d", a), v, 32'd0);
        end
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);

        // N=5 with Go register visible while running
        bus_wr(ADDR_N, 32'd5);
        bus_rd(ADDR_N, v);
        chk("n_readback", v, 32'd5);
        bus_wr(ADDR_GO, 32'd1);
        bus_rd(ADDR_GO, v);
        chk("go_set", v, 32'd1);
        for (int i = 1; i < 6; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("n5_busy_e%0d", i), 32'(busy), 32'd1);
            chk($sformatf("n5_done_e%0d", i), 32'(done), 32'd0);
        end
        @(posedge clk);
        #1;
        chk("n5_done", 32'(done), 32'd1);
        bus_rd(ADDR_RESULT, v);
        chk("n5_result", v, 32'd120);
        bus_rd(ADDR_STATUS, v);
        chk("n5_status", v, 32'h1);
        bus_rd(ADDR_GO, v);
        chk("go_cleared", v, 32'd0);

        // Boundary operands
        run_fact(0, 32'd1, 2, 1'b0);
        run_fact(1, 32'd1, 2, 1'b0);
        run_fact(12, 32'h1C8C_FC00, 13, 1'b0);
        run_fact(13, 32'd0, 1, 1'b1);
        run_fact(3, 32'd6, 4, 1'b0);

        // Writes while busy are ignored
        bus_wr(ADDR_N, 32'd10);
        bus_wr(ADDR_GO, 32'd1);
        @(posedge clk);
        bus_wr(ADDR_N, 32'd3);
        bus_wr(ADDR_GO, 32'd1);
        bus_rd(ADDR_N, v);
        chk("busy_n_write_ignored", v, 32'd10);
        for (int i = 4; i < 11; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("n10_done_e%0d", i), 32'(done), 32'd0);
        end
        @(posedge clk);
        #1;
        chk("n10_done", 32'(done), 32'd1);
        bus_rd(ADDR_RESULT, v);
        chk("n10_result", v, 32'h0037_5F00);

        // Async reset mid-run
        bus_wr(ADDR_N, 32'd12);
        bus_wr(ADDR_GO, 32'd1);
        repeat (4) @(posedge clk);
        #3;
        chk("pre_reset_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        bus_rd(ADDR_RESULT, v);
        chk("rst_result", v, 32'd0);
        bus_rd(ADDR_N, v);
        chk("rst_n_reg", v, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_done", 32'(done), 32'd0);
        run_fact(4, 32'd24, 5, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
